// File: rtl/bsearch_ctrl_if.sv
// Probe/flag bundle between the binary-search controller and its magnitude comparator,
// plus the start request and the search report.
interface bsearch_ctrl_if #(
  parameter int SIZE   = 4,
  parameter int STEP_W = 5
);
  logic              start;
  logic              eq_in;
  logic              gt_in;
  logic              lt_in;
  logic [SIZE-1:0]   guess;
  logic              busy;
  logic              done;
  logic              found;
  logic              error;
  logic [SIZE-1:0]   result;
  logic [STEP_W-1:0] steps;

  modport master (
    input  start, eq_in, gt_in, lt_in,
    output guess, busy, done, found, error, result, steps
  );

  modport slave (
    output start, eq_in, gt_in, lt_in,
    input  guess, busy, done, found, error, result, steps
  );
endinterface

// File: rtl/bsearch_ctrl.sv
// Binary-search controller: drives a registered guess into an external comparator and
// narrows [lo,hi] from its eq/gt/lt flags until a match, an empty range, or a bad flag set.
module bsearch_ctrl #(
  parameter int SIZE   = 4,
  parameter int STEP_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  bsearch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [SIZE:0] MAX = {1'b0, {SIZE{1'b1}}};

  state_t            state;
  state_t            state_nxt;

  // Bounds carry one extra bit so guess+1 at MAX and guess-1 at 0 never alias.
  logic [SIZE:0]     lo;
  logic [SIZE:0]     hi;
  logic [SIZE:0]     sum_lh;
  logic [SIZE:0]     guess_inc;
  logic [SIZE:0]     guess_dec;

  logic [SIZE-1:0]   guess_q;
  logic [SIZE-1:0]   result_q;
  logic [STEP_W-1:0] steps_q;
  logic              found_q;
  logic              error_q;

  logic [2:0]        flags;
  logic              one_hot;
  logic              gt_exhausted;
  logic              lt_exhausted;

  assign flags        = {bus.eq_in, bus.gt_in, bus.lt_in};
  assign one_hot      = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign sum_lh       = lo + hi;
  assign guess_inc    = {1'b0, guess_q} + (SIZE+1)'(1);
  assign guess_dec    = {1'b0, guess_q} - (SIZE+1)'(1);
  assign gt_exhausted = guess_inc > hi;
  assign lt_exhausted = (guess_q == '0) || (guess_dec < lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_PROBE;
      end
      S_PROBE: begin
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (!one_hot || bus.eq_in) begin
          state_nxt = S_DONE;
        end else if (bus.gt_in) begin
          state_nxt = gt_exhausted ? S_DONE : S_PROBE;
        end else begin
          state_nxt = lt_exhausted ? S_DONE : S_PROBE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo       <= '0;
      hi       <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo       <= '0;
            hi       <= MAX;
            steps_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
          end
        end
        S_PROBE: begin
          guess_q <= SIZE'(sum_lh >> 1);
        end
        S_EVAL: begin
          steps_q <= steps_q + STEP_W'(1);
          if (!one_hot) begin
            error_q <= 1'b1;
            found_q <= 1'b0;
          end else if (bus.eq_in) begin
            found_q  <= 1'b1;
            result_q <= guess_q;
          end else if (bus.gt_in) begin
            if (gt_exhausted) found_q <= 1'b0;
            else              lo      <= guess_inc;
          end else begin
            if (lt_exhausted) found_q <= 1'b0;
            else              hi      <= guess_dec;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // busy/done come only from the state register, never from the flag inputs.
  always_comb begin
    bus.busy   = (state != S_IDLE);
    bus.done   = (state == S_DONE);
    bus.guess  = guess_q;
    bus.found  = found_q;
    bus.error  = error_q;
    bus.result = result_q;
    bus.steps  = steps_q;
  end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Bench for bsearch_ctrl: a flag-level comparator, an integer binary-search model that
// expands into per-cycle expectations, and one negedge compare process.
module tb_bsearch_ctrl;

  localparam int SIZE   = 4;
  localparam int STEP_W = 5;
  localparam int MAXV   = 15;

  // comparator modes: 0 true comparator, 1 stuck lt, 2 stuck gt, 3 flags 000,
  // 4 flags 110, 5 true comparator on 13 except 111 when guess hits 13
  logic clk;
  logic rst;
  int   mode;
  int   target;

  bsearch_ctrl_if #(.SIZE(SIZE), .STEP_W(STEP_W)) bus ();

  bsearch_ctrl #(.SIZE(SIZE), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] flags_of(input int md, input int tg, input int g);
    logic [2:0] f;
    f = 3'b000;
    case (md)
      0: f = {g == tg, tg > g, tg < g};
      1: f = 3'b001;
      2: f = 3'b010;
      3: f = 3'b000;
      4: f = 3'b110;
      5: f = (g == 13) ? 3'b111 : {1'b0, 13 > g, 13 < g};
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  always_comb begin
    {bus.eq_in, bus.gt_in, bus.lt_in} = flags_of(mode, target, int'(bus.guess));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Model: plain integer binary search over [0,MAXV] driven by the comparator answers.
  int m_g[0:31];
  int m_k;
  int m_found;
  int m_err;
  int m_res;

  function automatic void run_model(input int md, input int tg);
    int lo = 0;
    int hi = MAXV;
    int g;
    logic [2:0] f;
    m_k = 0; m_found = 0; m_err = 0; m_res = 0;
    for (int i = 0; i < 32; i++) begin
      g = (lo + hi) / 2;
      m_g[m_k] = g;
      m_k++;
      f = flags_of(md, tg, g);
      if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin
        m_err = 1;
        break;
      end
      if (f == 3'b100) begin
        m_found = 1;
        m_res = g;
        break;
      end
      if (f == 3'b010) begin
        if (g + 1 > hi) break;
        lo = g + 1;
      end else begin
        if (g == 0 || g - 1 < lo) break;
        hi = g - 1;
      end
    end
  endfunction

  typedef struct {
    int name_id;
    int busy;
    int done;
    int guess;
    int steps;
    int found;
    int err;
    int res;
  } exp_t;

  exp_t expq[$];
  int   last_guess = 0;
  int   rec_id = 0;

  // Record m describes the cycle after the m-th edge following the accepting edge;
  // two edges per probe, so done sits in the cycle closing at edge T+2k+1.
  function automatic void push_search(input int md, input int tg, input int maxr);
    exp_t e;
    run_model(md, tg);
    for (int m = 0; m <= 2 * m_k; m++) begin
      if (m < maxr) begin
        e.name_id = rec_id++;
        e.busy  = 1;
        e.done  = (m == 2 * m_k) ? 1 : 0;
        e.guess = (m == 0) ? last_guess : m_g[(m - 1) / 2];
        e.steps = m / 2;
        e.found = (m == 2 * m_k) ? m_found : 0;
        e.err   = (m == 2 * m_k) ? m_err : 0;
        e.res   = (m == 2 * m_k) ? m_res : 0;
        expq.push_back(e);
      end
    end
    if (2 * m_k + 1 < maxr) begin
      e.name_id = rec_id++;
      e.busy  = 0;
      e.done  = 0;
      e.guess = m_g[m_k - 1];
      e.steps = m_k;
      e.found = m_found;
      e.err   = m_err;
      e.res   = m_res;
      expq.push_back(e);
    end
    last_guess = m_g[m_k - 1];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk($sformatf("busy[%0d]", e.name_id), bus.busy, e.busy);
      chk($sformatf("done[%0d]", e.name_id), bus.done, e.done);
      chk($sformatf("guess[%0d]", e.name_id), bus.guess, e.guess);
      chk($sformatf("steps[%0d]", e.name_id), bus.steps, e.steps);
      chk($sformatf("found[%0d]", e.name_id), bus.found, e.found);
      chk($sformatf("error[%0d]", e.name_id), bus.error, e.err);
      chk($sformatf("result[%0d]", e.name_id), bus.result, e.res);
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", 1, 0);
      expq.delete();
    end
  endtask

  task automatic search(input int md, input int tg, input bit pulse);
    int k;
    @(posedge clk); #1;
    mode = md;
    target = tg;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    push_search(md, tg, 1000);
    k = m_k;
    if (pulse) begin
      // start raised while probing and again while in DONE; neither may be taken.
      for (int n = 1; n <= 2 * k + 1; n++) begin
        @(posedge clk); #1;
        bus.start = (n == 3 || n == 2 * k) ? 1'b1 : 1'b0;
      end
    end
    wait_drain(200);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_guess"}, bus.guess, 0);
    chk({tag, "_found"}, bus.found, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_steps"}, bus.steps, 0);
  endtask

  initial begin
    int k1;
    rst = 1'b1;
    bus.start = 1'b0;
    mode = 0;
    target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Hand-computed pins on the model itself.
    run_model(0, 13);
    chk("pin13_k", m_k, 3);
    chk("pin13_g0", m_g[0], 7);
    chk("pin13_g1", m_g[1], 11);
    chk("pin13_g2", m_g[2], 13);
    chk("pin13_res", m_res, 13);
    run_model(0, 0);
    chk("pin0_k", m_k, 4);
    chk("pin0_g3", m_g[3], 0);
    run_model(0, 15);
    chk("pin15_k", m_k, 5);
    run_model(1, 0);
    chk("pinlt_k", m_k, 4);
    chk("pinlt_found", m_found, 0);
    run_model(2, 0);
    chk("pingt_k", m_k, 5);
    chk("pingt_g4", m_g[4], 15);
    run_model(3, 0);
    chk("pin000_err", m_err, 1);
    chk("pin000_k", m_k, 1);

    search(0, 13, 0);
    chk("t13_result", bus.result, 13);
    chk("t13_steps", bus.steps, 3);
    chk("t13_found", bus.found, 1);
    search(0, 0, 0);
    chk("t0_steps", bus.steps, 4);
    search(0, 15, 0);
    chk("t15_steps", bus.steps, 5);
    chk("t15_result", bus.result, 15);
    search(1, 0, 0);
    search(2, 0, 0);
    chk("stuckgt_found", bus.found, 0);
    search(3, 0, 0);
    chk("f000_error", bus.error, 1);
    chk("f000_steps", bus.steps, 1);
    search(4, 0, 0);
    search(5, 13, 0);
    chk("f111_error", bus.error, 1);
    chk("f111_steps", bus.steps, 3);
    search(0, 6, 0);

    // Reset in the middle of the second EVAL (target 13).
    @(posedge clk); #1;
    mode = 0;
    target = 13;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    push_search(0, 13, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    last_guess = 0;
    @(posedge clk); #1;
    chk_all_zero("midrst_hold");
    rst = 1'b0;
    search(0, 13, 0);
    chk("postrst_steps", bus.steps, 3);

    search(0, 13, 1);
    chk("pulse_result", bus.result, 13);
    chk("pulse_busy", bus.busy, 0);

    // Start held high: two searches separated by exactly one IDLE cycle.
    @(posedge clk); #1;
    mode = 0;
    target = 9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    push_search(0, 9, 1000);
    k1 = m_k;
    repeat (2 * k1 + 2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    target = 9;
    push_search(0, 9, 1000);
    wait_drain(200);
    chk("b2b_result", bus.result, 9);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
